// File: rtl/cache_pkg.sv
// cache_pkg: shared widths, FSM states and address field positions
// for the direct-mapped write-back cache controller.
package cache_pkg;

   localparam int ADDR_W     = 16;
   localparam int SRAM_AW    = 8;
   localparam int TAG_W      = 8;
   localparam int LINES      = 8;
   localparam int LINE_BYTES = 32;
   localparam int WAIT_DEF   = 4;

   localparam int OFF_LSB = 0;
   localparam int OFF_MSB = 4;
   localparam int IDX_LSB = 5;
   localparam int IDX_MSB = 7;
   localparam int TAG_LSB = 8;
   localparam int TAG_MSB = 15;

   typedef enum logic [2:0] {
      S_IDLE,
      S_COMPARE,
      S_WRITEBACK,
      S_REFILL,
      S_ACCESS
   } state_t;

endpackage

// File: rtl/cache_tag_array.sv
// cache_tag_array: per-line valid, dirty and tag store.
// Combinational read by index, clocked write, async clear.
module cache_tag_array
   import cache_pkg::*;
#(
   parameter int DEPTH    = LINES,
   parameter int TAG_SIZE = TAG_W,
   localparam int IW      = $clog2(DEPTH)
)(
   input  logic                clk,
   input  logic                rst,
   input  logic [IW-1:0]       i_rd_idx,
   output logic                o_valid,
   output logic                o_dirty,
   output logic [TAG_SIZE-1:0] o_tag,
   input  logic                i_we,
   input  logic [IW-1:0]       i_wr_idx,
   input  logic                i_valid,
   input  logic                i_dirty,
   input  logic [TAG_SIZE-1:0] i_tag
);

   logic [DEPTH-1:0]    r_valid;
   logic [DEPTH-1:0]    r_dirty;
   logic [TAG_SIZE-1:0] r_tag [DEPTH];

   assign o_valid = r_valid[i_rd_idx];
   assign o_dirty = r_dirty[i_rd_idx];
   assign o_tag   = r_tag[i_rd_idx];

   // Line metadata update; reset invalidates every line
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_valid <= '0;
         r_dirty <= '0;
         for (int k = 0; k < DEPTH; k++) r_tag[k] <= '0;
      end else if (i_we) begin
         r_valid[i_wr_idx] <= i_valid;
         r_dirty[i_wr_idx] <= i_dirty;
         r_tag[i_wr_idx]   <= i_tag;
      end
   end

endmodule

// File: rtl/cache_ctrl.sv
// cache_ctrl: direct-mapped write-back write-allocate cache controller
// driving an external SRAM data array and a slow SDRAM.
module cache_ctrl
   import cache_pkg::*;
#(
   parameter int ADDR_WIDTH      = ADDR_W,
   parameter int ADDR_WIDTH_SRAM = SRAM_AW,
   parameter int TAG_SIZE        = TAG_W,
   parameter int DEPTH           = LINES,
   parameter int WORDS           = LINE_BYTES,
   parameter int SDRAM_WAIT      = WAIT_DEF
)(
   input  logic                       clk,
   input  logic                       rst,
   input  logic [ADDR_WIDTH-1:0]      Address_cpu,
   input  logic                       wr_rd_cpu,
   input  logic                       cs_cpu,
   output logic                       rdy_cpu,
   output logic [ADDR_WIDTH-1:0]      Address_sdram,
   output logic                       wr_rd_sdram,
   output logic                       mstrb_sdram,
   output logic                       mux_sel,
   output logic                       demux_sel,
   output logic                       wen_sram,
   output logic [ADDR_WIDTH_SRAM-1:0] address_cache_ctrl_sram
);

   localparam int IW = $clog2(DEPTH);
   localparam int OW = $clog2(WORDS);
   localparam int CW = $clog2(SDRAM_WAIT);

   state_t                r_state;
   state_t                w_next;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic                  r_wr;
   logic [OW-1:0]         r_word;
   logic [CW-1:0]         r_wait;

   logic [TAG_SIZE-1:0]   w_tag;
   logic [IW-1:0]         w_idx;
   logic [OW-1:0]         w_off;
   logic                  w_valid;
   logic                  w_dirty;
   logic [TAG_SIZE-1:0]   w_old_tag;
   logic                  w_hit;
   logic                  w_first;
   logic                  w_last;
   logic                  w_wrap;
   logic                  w_burst;
   logic                  w_we;
   logic                  w_we_valid;
   logic                  w_we_dirty;

   assign w_tag   = r_addr[TAG_MSB:TAG_LSB];
   assign w_idx   = r_addr[IDX_MSB:IDX_LSB];
   assign w_off   = r_addr[OFF_MSB:OFF_LSB];
   assign w_hit   = w_valid && (w_old_tag == w_tag);
   assign w_first = (r_wait == '0);
   assign w_last  = (r_wait == CW'(SDRAM_WAIT - 1));
   assign w_wrap  = w_last && (r_word == OW'(WORDS - 1));
   assign w_burst = (r_state == S_WRITEBACK) || (r_state == S_REFILL);

   cache_tag_array #(
      .DEPTH    (DEPTH),
      .TAG_SIZE (TAG_SIZE)
   ) u_tags (
      .clk      (clk),
      .rst      (rst),
      .i_rd_idx (w_idx),
      .o_valid  (w_valid),
      .o_dirty  (w_dirty),
      .o_tag    (w_old_tag),
      .i_we     (w_we),
      .i_wr_idx (w_idx),
      .i_valid  (w_we_valid),
      .i_dirty  (w_we_dirty),
      .i_tag    (w_tag)
   );

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= S_IDLE;
      else      r_state <= w_next;
   end

   // Latch the CPU request only when idle
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_addr <= '0;
         r_wr   <= 1'b0;
      end else if (r_state == S_IDLE && cs_cpu) begin
         r_addr <= Address_cpu;
         r_wr   <= wr_rd_cpu;
      end
   end

   // Word and wait counters step only during bursts
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_word <= '0;
         r_wait <= '0;
      end else if (!w_burst) begin
         r_word <= '0;
         r_wait <= '0;
      end else if (w_last) begin
         r_wait <= '0;
         r_word <= r_word + 1'b1;
      end else begin
         r_wait <= r_wait + 1'b1;
      end
   end

   // Next state, SDRAM/SRAM controls and tag updates
   always_comb begin
      w_next                  = r_state;
      rdy_cpu                 = 1'b0;
      Address_sdram           = '0;
      wr_rd_sdram             = 1'b0;
      mstrb_sdram             = 1'b0;
      mux_sel                 = 1'b0;
      demux_sel               = 1'b0;
      wen_sram                = 1'b0;
      address_cache_ctrl_sram = '0;
      w_we                    = 1'b0;
      w_we_valid              = 1'b0;
      w_we_dirty              = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            rdy_cpu = 1'b1;
            if (cs_cpu) w_next = S_COMPARE;
         end
         S_COMPARE: begin
            if (w_hit)                w_next = S_ACCESS;
            else if (w_valid && w_dirty) w_next = S_WRITEBACK;
            else                      w_next = S_REFILL;
         end
         S_WRITEBACK: begin
            address_cache_ctrl_sram = {w_idx, r_word};
            Address_sdram           = {w_old_tag, w_idx, r_word};
            wr_rd_sdram             = 1'b1;
            mstrb_sdram             = w_first;
            demux_sel               = w_first;
            if (w_wrap) w_next = S_REFILL;
         end
         S_REFILL: begin
            address_cache_ctrl_sram = {w_idx, r_word};
            Address_sdram           = {w_tag, w_idx, r_word};
            mstrb_sdram             = w_first;
            mux_sel                 = w_last;
            wen_sram                = w_last;
            if (w_wrap) begin
               w_next     = S_ACCESS;
               w_we       = 1'b1;
               w_we_valid = 1'b1;
            end
         end
         S_ACCESS: begin
            address_cache_ctrl_sram = {w_idx, w_off};
            if (r_wr) begin
               wen_sram   = 1'b1;
               w_we       = 1'b1;
               w_we_valid = 1'b1;
               w_we_dirty = 1'b1;
            end
            w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_cache_ctrl.sv
// tb_cache_ctrl: directed scenarios for cache_ctrl with SDRAM_WAIT=4;
// latency counted in edges starting at the cs_cpu sampling edge.
module tb_cache_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [15:0] Address_cpu = '0;
   logic        wr_rd_cpu = 1'b0;
   logic        cs_cpu = 1'b0;
   logic        rdy_cpu;
   logic [15:0] Address_sdram;
   logic        wr_rd_sdram;
   logic        mstrb_sdram;
   logic        mux_sel;
   logic        demux_sel;
   logic        wen_sram;
   logic [7:0]  address_cache_ctrl_sram;

   int n_chk  = 0;
   int n_pass = 0;

   logic [15:0] stb_addr  [64];
   logic        stb_wr    [64];
   logic        stb_demux [64];
   int          stb_cyc   [64];
   logic [7:0]  wen_addr  [64];
   logic        wen_mux   [64];
   int          nstb, nwen, stray, lat;
   logic [7:0]  last_sram;
   logic        last_demux, last_mux, last_wen;

   cache_ctrl dut (
      .clk                     (clk),
      .rst                     (rst),
      .Address_cpu             (Address_cpu),
      .wr_rd_cpu               (wr_rd_cpu),
      .cs_cpu                  (cs_cpu),
      .rdy_cpu                 (rdy_cpu),
      .Address_sdram           (Address_sdram),
      .wr_rd_sdram             (wr_rd_sdram),
      .mstrb_sdram             (mstrb_sdram),
      .mux_sel                 (mux_sel),
      .demux_sel               (demux_sel),
      .wen_sram                (wen_sram),
      .address_cache_ctrl_sram (address_cache_ctrl_sram)
   );

   always #5 clk = ~clk;

   task automatic run_req(input logic [15:0] a, input logic w,
                          input bit hold, input bit rel);
      nstb = 0; nwen = 0; stray = 0; lat = 0;
      @(negedge clk);
      if (rel) rst = 1'b1;
      Address_cpu = a; wr_rd_cpu = w; cs_cpu = 1'b1;
      for (int n = 1; n <= 400; n++) begin
         @(posedge clk); #1;
         if (!hold) cs_cpu = 1'b0;
         if (mstrb_sdram) begin
            if (nstb < 64) begin
               stb_addr[nstb]  = Address_sdram;
               stb_wr[nstb]    = wr_rd_sdram;
               stb_demux[nstb] = demux_sel;
               stb_cyc[nstb]   = n;
            end
            nstb++;
         end
         if (wen_sram) begin
            if (nwen < 64) begin
               wen_addr[nwen] = address_cache_ctrl_sram;
               wen_mux[nwen]  = mux_sel;
            end
            nwen++;
         end
         if (demux_sel && !mstrb_sdram) stray++;
         if (mux_sel && !wen_sram) stray++;
         if (rdy_cpu) begin
            lat = n;
            break;
         end
         last_sram  = address_cache_ctrl_sram;
         last_demux = demux_sel;
         last_mux   = mux_sel;
         last_wen   = wen_sram;
      end
   endtask

   task automatic test_reset();
      #2;
      n_chk++;
      if (rdy_cpu !== 1'b1) $display("FAIL reset_rdy got %b want 1", rdy_cpu);
      else n_pass++;
      n_chk++;
      if ({mstrb_sdram, wen_sram, mux_sel, demux_sel, wr_rd_sdram, Address_sdram,
           address_cache_ctrl_sram} !== 29'h0)
         $display("FAIL reset_outs got %b%b%b%b%b %h %h want all zero",
                  mstrb_sdram, wen_sram, mux_sel, demux_sel, wr_rd_sdram,
                  Address_sdram, address_cache_ctrl_sram);
      else n_pass++;
   endtask

   task automatic test_read_miss();
      int bad = 0;
      run_req(16'h1234, 1'b0, 1'b0, 1'b1);
      n_chk++;
      if (lat !== 131) $display("FAIL miss_lat got %0d want 131", lat);
      else n_pass++;
      n_chk++;
      if (nstb !== 32) $display("FAIL miss_nstb got %0d want 32", nstb);
      else n_pass++;
      n_chk++;
      if (stb_cyc[0] !== 2) $display("FAIL miss_first_stb got %0d want 2", stb_cyc[0]);
      else n_pass++;
      for (int k = 0; k < 32; k++)
         if (stb_addr[k] !== 16'h1220 + 16'(k) || stb_wr[k] !== 1'b0 ||
             stb_cyc[k] !== 2 + 4 * k) bad++;
      n_chk++;
      if (bad !== 0) $display("FAIL miss_stb_seq got %0d bad want 0", bad);
      else n_pass++;
      bad = 0;
      for (int k = 0; k < 32; k++)
         if (wen_addr[k] !== 8'h20 + 8'(k) || wen_mux[k] !== 1'b1) bad++;
      n_chk++;
      if (nwen !== 32 || bad !== 0)
         $display("FAIL miss_refill_wen got n=%0d bad=%0d want n=32 bad=0", nwen, bad);
      else n_pass++;
      n_chk++;
      if (stray !== 0) $display("FAIL miss_stray got %0d want 0", stray);
      else n_pass++;
   endtask

   task automatic test_read_hit();
      run_req(16'h1235, 1'b0, 1'b0, 1'b0);
      n_chk++;
      if (lat !== 3 || nstb !== 0 || nwen !== 0)
         $display("FAIL hit_rd got lat=%0d stb=%0d wen=%0d want 3/0/0", lat, nstb, nwen);
      else n_pass++;
      n_chk++;
      if (last_sram !== 8'h35 || last_demux !== 1'b0)
         $display("FAIL hit_rd_sram got %h demux=%b want 35 demux=0", last_sram, last_demux);
      else n_pass++;
   endtask

   task automatic test_dirty_miss();
      int bad = 0;
      run_req(16'h1236, 1'b1, 1'b0, 1'b0);
      n_chk++;
      if (lat !== 3 || nstb !== 0 || nwen !== 1 || wen_addr[0] !== 8'h36 || wen_mux[0] !== 1'b0)
         $display("FAIL hit_wr got lat=%0d stb=%0d wen=%0d a=%h mux=%b want 3/0/1/36/0",
                  lat, nstb, nwen, wen_addr[0], wen_mux[0]);
      else n_pass++;
      run_req(16'h5530, 1'b0, 1'b0, 1'b0);
      n_chk++;
      if (lat !== 259) $display("FAIL dirty_lat got %0d want 259", lat);
      else n_pass++;
      n_chk++;
      if (nstb !== 64) $display("FAIL dirty_nstb got %0d want 64", nstb);
      else n_pass++;
      for (int k = 0; k < 32; k++) begin
         if (stb_addr[k] !== 16'h1220 + 16'(k) || stb_wr[k] !== 1'b1 ||
             stb_demux[k] !== 1'b1) bad++;
         if (stb_addr[k+32] !== 16'h5520 + 16'(k) || stb_wr[k+32] !== 1'b0 ||
             stb_demux[k+32] !== 1'b0) bad++;
      end
      n_chk++;
      if (bad !== 0) $display("FAIL dirty_stb_seq got %0d bad want 0", bad);
      else n_pass++;
      n_chk++;
      if (stb_cyc[32] !== 130) $display("FAIL dirty_refill_start got %0d want 130", stb_cyc[32]);
      else n_pass++;
      n_chk++;
      if (nwen !== 32 || stray !== 0 || last_sram !== 8'h30)
         $display("FAIL dirty_misc got wen=%0d stray=%0d sram=%h want 32/0/30",
                  nwen, stray, last_sram);
      else n_pass++;
   endtask

   task automatic test_cs_held();
      run_req(16'h0000, 1'b0, 1'b1, 1'b0);
      n_chk++;
      if (lat !== 131 || nstb !== 32)
         $display("FAIL held_first got lat=%0d stb=%0d want 131/32", lat, nstb);
      else n_pass++;
      @(posedge clk); #1;
      cs_cpu = 1'b0;
      n_chk++;
      if (rdy_cpu !== 1'b0) $display("FAIL held_next_accept got rdy=%b want 0", rdy_cpu);
      else n_pass++;
      @(posedge clk); #1;
      n_chk++;
      if (mstrb_sdram !== 1'b0 || rdy_cpu !== 1'b0)
         $display("FAIL held_next_hit got stb=%b rdy=%b want 0/0", mstrb_sdram, rdy_cpu);
      else n_pass++;
      @(posedge clk); #1;
      n_chk++;
      if (rdy_cpu !== 1'b1) $display("FAIL held_next_done got rdy=%b want 1", rdy_cpu);
      else n_pass++;
   endtask

   task automatic test_reset_mid_refill();
      int k = 0;
      int late = 0;
      @(negedge clk);
      Address_cpu = 16'h7700; wr_rd_cpu = 1'b0; cs_cpu = 1'b1;
      for (int n = 1; n <= 200; n++) begin
         @(posedge clk); #1;
         cs_cpu = 1'b0;
         if (mstrb_sdram) k++;
         if (k == 11) break;
      end
      n_chk++;
      if (k !== 11 || Address_sdram !== 16'h770A)
         $display("FAIL rst_mid_reach got k=%0d addr=%h want 11/770a", k, Address_sdram);
      else n_pass++;
      #2 rst = 1'b0;
      #1;
      n_chk++;
      if (rdy_cpu !== 1'b1 || mstrb_sdram !== 1'b0 || wen_sram !== 1'b0 ||
          mux_sel !== 1'b0 || Address_sdram !== 16'h0)
         $display("FAIL rst_mid_outs got rdy=%b stb=%b wen=%b mux=%b a=%h want 1/0/0/0/0",
                  rdy_cpu, mstrb_sdram, wen_sram, mux_sel, Address_sdram);
      else n_pass++;
      for (int n = 0; n < 3; n++) begin
         @(posedge clk); #1;
         if (mstrb_sdram || wen_sram) late++;
      end
      n_chk++;
      if (late !== 0) $display("FAIL rst_mid_quiet got %0d want 0", late);
      else n_pass++;
      run_req(16'h7700, 1'b0, 1'b0, 1'b1);
      n_chk++;
      if (lat !== 131 || nstb !== 32 || stb_addr[0] !== 16'h7700 || stb_addr[31] !== 16'h771F)
         $display("FAIL rst_mid_reread got lat=%0d stb=%0d a0=%h a31=%h want 131/32/7700/771f",
                  lat, nstb, stb_addr[0], stb_addr[31]);
      else n_pass++;
      run_req(16'h7705, 1'b0, 1'b0, 1'b0);
      n_chk++;
      if (lat !== 3 || nstb !== 0)
         $display("FAIL rst_mid_hit got lat=%0d stb=%0d want 3/0", lat, nstb);
      else n_pass++;
   endtask

   initial begin
      test_reset();
      test_read_miss();
      test_read_hit();
      test_dirty_miss();
      test_cs_held();
      test_reset_mid_refill();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
